// File: rtl/lcd_window_scheduler.sv
// lcd_window_scheduler
//   Word source for the shared LCD SPI serializer on the 4-up gauge board.
//   It grants one of four gauge renderers and drops that LCD's chip select.
//   It then pushes CASET/RASET/RAMWR through a one-entry holding register,
//   with the matching D/C level, and streams the window's 16-bit pixels.
//   Finally it closes the transaction with a CS hold time and a done pulse.
//
// Parameters
//   CS_SETUP  clocks from CS low to the first command byte (1..15)
//   CS_HOLD   clocks from serializer idle to CS high, and the minimum
//             idle gap before the next grant (1..15)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req[3:0]                 per-channel draw request (level)
//   win_x0/x1/y0/y1[31:0]    per-channel inclusive window, channel n at [8n+7:8n]
//   gnt[3:0], done[3:0]      one-hot owner / end-of-transaction pulse
//   pix_data, pix_valid      pixel stream of the granted channel
//   pix_ready                pixel accepted when pix_valid is also high
//   d8_empty/d8_data/d8_read     command/parameter byte handshake
//   d16_empty/d16_data/d16_read  pixel word handshake
//   lcd_busy                 serializer shifting
//   lcd_dc, lcd_cs_n[3:0]    D/C level and per-LCD chip selects
//
// Build option
//   LCD_SCHED_RR_EN  defined: round-robin grant; undefined: fixed priority (ch0 highest)

module lcd_window_scheduler #(
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] win_x0,
   input  logic [31:0] win_x1,
   input  logic [31:0] win_y0,
   input  logic [31:0] win_y1,
   output logic [3:0]  gnt,
   output logic [3:0]  done,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        d8_empty,
   output logic [7:0]  d8_data,
   input  logic        d8_read,
   output logic        d16_empty,
   output logic [15:0] d16_data,
   input  logic        d16_read,
   input  logic        lcd_busy,
   output logic        lcd_dc,
   output logic [3:0]  lcd_cs_n
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SEQ, S_DRAIN, S_PIX, S_CLOSE, S_HOLD
   } state_e;

   state_e      state_q;
   logic [3:0]  gnt_q, done_q, cs_n_q;
   logic        dc_q;
   logic [7:0]  x0_q, x1_q, y0_q, y1_q;
   logic [3:0]  idx_q;
   logic [16:0] cnt_q;
   logic [3:0]  tmr_q, gap_q;
   logic        hold_v_q, hold_w16_q;
   logic [7:0]  d8_q;
   logic [15:0] d16_q;
`ifdef LCD_SCHED_RR_EN
   logic [1:0]  ptr_q;
`endif

   logic        hold_rd_d, hold_free_d, pix_acc_d;
   logic        pick_ok_d;
   logic [1:0]  pick_ch_d, scan_c_d;
   logic [7:0]  seq_byte_d;
   logic        seq_dc_d;
   logic [8:0]  dx_d, dy_d;
   logic [16:0] pix_total_d;

   // The register frees in the same cycle its matching read is seen.
   // That lets a new word load on the same edge (no serializer idle).
   assign hold_rd_d   = hold_v_q & ((~hold_w16_q & d8_read) | (hold_w16_q & d16_read));
   assign hold_free_d = ~hold_v_q | hold_rd_d;
   assign pix_ready   = (state_q == S_PIX) && (cnt_q != '0) && hold_free_d;
   assign pix_acc_d   = pix_ready & pix_valid;

   always_comb begin
      pick_ok_d = 1'b0;
      pick_ch_d = '0;
      scan_c_d  = '0;
      for (int unsigned i = 0; i < 4; i++) begin
`ifdef LCD_SCHED_RR_EN
         scan_c_d = ptr_q + i[1:0];
`else
         scan_c_d = i[1:0];
`endif
         if (!pick_ok_d && req[scan_c_d]) begin
            pick_ok_d = 1'b1;
            pick_ch_d = scan_c_d;
         end
      end
   end

   always_comb begin
      case (idx_q)
         4'd0:    seq_byte_d = 8'h2A;
         4'd2:    seq_byte_d = x0_q;
         4'd4:    seq_byte_d = x1_q;
         4'd5:    seq_byte_d = 8'h2B;
         4'd7:    seq_byte_d = y0_q;
         4'd9:    seq_byte_d = y1_q;
         4'd10:   seq_byte_d = 8'h2C;
         default: seq_byte_d = 8'h00;
      endcase
      seq_dc_d = !((idx_q == 4'd0) || (idx_q == 4'd5) || (idx_q == 4'd10));
   end

   // A swapped window yields zero pixels; the command bytes still carry raw values.
   always_comb begin
      dx_d = {1'b0, x1_q} - {1'b0, x0_q} + 9'd1;
      dy_d = {1'b0, y1_q} - {1'b0, y0_q} + 9'd1;
      if ((x1_q < x0_q) || (y1_q < y0_q)) pix_total_d = '0;
      else                                pix_total_d = {8'd0, dx_d} * {8'd0, dy_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gnt_q      <= '0;
         done_q     <= '0;
         cs_n_q     <= '1;
         dc_q       <= 1'b0;
         x0_q       <= '0;
         x1_q       <= '0;
         y0_q       <= '0;
         y1_q       <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         tmr_q      <= '0;
         gap_q      <= '0;
         hold_v_q   <= 1'b0;
         hold_w16_q <= 1'b0;
         d8_q       <= '0;
         d16_q      <= '0;
`ifdef LCD_SCHED_RR_EN
         ptr_q      <= '0;
`endif
      end else begin
         done_q <= '0;
         if (hold_rd_d) hold_v_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - 4'd1;
               end else if (pick_ok_d) begin
                  gnt_q   <= 4'b0001 << pick_ch_d;
                  x0_q    <= win_x0[{pick_ch_d, 3'b000} +: 8];
                  x1_q    <= win_x1[{pick_ch_d, 3'b000} +: 8];
                  y0_q    <= win_y0[{pick_ch_d, 3'b000} +: 8];
                  y1_q    <= win_y1[{pick_ch_d, 3'b000} +: 8];
                  tmr_q   <= 4'(CS_SETUP - 1);
                  state_q <= S_SETUP;
`ifdef LCD_SCHED_RR_EN
                  ptr_q   <= pick_ch_d + 2'd1;
`endif
               end
            end
            S_SETUP: begin
               cs_n_q <= ~gnt_q;
               if (tmr_q == '0) begin
                  idx_q   <= '0;
                  cnt_q   <= pix_total_d;
                  state_q <= S_SEQ;
               end else begin
                  tmr_q <= tmr_q - 4'd1;
               end
            end
            S_SEQ: begin
               if (idx_q == 4'd11) begin
                  state_q <= (cnt_q != '0) ? S_DRAIN : S_CLOSE;
               end else if (seq_dc_d != dc_q) begin
                  state_q <= S_DRAIN;
               end else if (hold_free_d) begin
                  hold_v_q   <= 1'b1;
                  hold_w16_q <= 1'b0;
                  d8_q       <= seq_byte_d;
                  idx_q      <= idx_q + 4'd1;
               end
            end
            // D/C only flips once the register is empty and the serializer is idle.
            // The byte list ending (idx 11) means the next phase is pixels.
            S_DRAIN: begin
               if (!hold_v_q && !lcd_busy) begin
                  dc_q    <= ~dc_q;
                  state_q <= (idx_q == 4'd11) ? S_PIX : S_SEQ;
               end
            end
            S_PIX: begin
               if (cnt_q == '0) begin
                  state_q <= S_CLOSE;
               end else if (pix_acc_d) begin
                  hold_v_q   <= 1'b1;
                  hold_w16_q <= 1'b1;
                  d16_q      <= pix_data;
                  cnt_q      <= cnt_q - 17'd1;
               end
            end
            S_CLOSE: begin
               if (!hold_v_q && !lcd_busy) begin
                  tmr_q   <= 4'(CS_HOLD - 1);
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (tmr_q == '0) begin
                  cs_n_q  <= '1;
                  done_q  <= gnt_q;
                  gnt_q   <= '0;
                  dc_q    <= 1'b0;
                  gap_q   <= 4'(CS_HOLD - 1);
                  state_q <= S_IDLE;
               end else begin
                  tmr_q <= tmr_q - 4'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign lcd_cs_n  = cs_n_q;
   assign lcd_dc    = dc_q;
   assign d8_empty  = ~(hold_v_q & ~hold_w16_q);
   assign d16_empty = ~(hold_v_q & hold_w16_q);
   assign d8_data   = d8_q;
   assign d16_data  = d16_q;

endmodule

// File: tb/tb_lcd_window_scheduler.sv
// Self-checking bench for lcd_window_scheduler.
// A serializer model consumes words, with a programmable word time.
// A pixel source feeds pixels in order.
// The expected word stream and grant order are built from window arithmetic.

module tb_lcd_window_scheduler;
   localparam int unsigned CSS = 2;
   localparam int unsigned CSH = 2;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] win_x0, win_x1, win_y0, win_y1;
   logic [3:0]  gnt, done;
   logic [15:0] pix_data;
   logic        pix_valid, pix_ready;
   logic        d8_empty, d8_read;
   logic [7:0]  d8_data;
   logic        d16_empty, d16_read;
   logic [15:0] d16_data;
   logic        lcd_busy, lcd_dc;
   logic [3:0]  lcd_cs_n;

   lcd_window_scheduler #(.CS_SETUP(CSS), .CS_HOLD(CSH)) dut (
      .clk(clk), .rst(rst), .req(req),
      .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
      .gnt(gnt), .done(done),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .d8_empty(d8_empty), .d8_data(d8_data), .d8_read(d8_read),
      .d16_empty(d16_empty), .d16_data(d16_data), .d16_read(d16_read),
      .lcd_busy(lcd_busy), .lcd_dc(lcd_dc), .lcd_cs_n(lcd_cs_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] data;
      logic        is16;
      logic        dc;
      logic [3:0]  cs_n;
   } word_t;

   word_t       exp_q[$];
   word_t       log_q[$];
   logic [15:0] src_q[$];
   int          exp_gnt_q[$];
   int          gnt_log[$];

   int errors = 0;
   int checks = 0;
   int wt = 3;
   int busy_cnt = 0;
   int cyc = 0;
   int done_cnt = 0;
   int pix_seen = 0;
   bit gate3 = 0;
   bit no_pix = 0;
   bit chk_on = 0;

   task automatic chk(input bit ok, input string name, input longint act, input longint want);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic capture(input logic [15:0] d, input logic w16);
      word_t w;
      word_t e;
      w.data = d;
      w.is16 = w16;
      w.dc   = lcd_dc;
      w.cs_n = lcd_cs_n;
      log_q.push_back(w);
      if (w16) pix_seen++;
      chk(exp_q.size() != 0, "word_expected", d, 0);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk(w.data == e.data, "word_data", w.data, e.data);
         chk(w.is16 == e.is16, "word_width16", w.is16, e.is16);
         chk(w.dc == e.dc, "word_dc", w.dc, e.dc);
         chk(w.cs_n == e.cs_n, "word_cs_n", w.cs_n, e.cs_n);
      end
   endtask

   // Model of one transaction: 11 command/parameter bytes, then every pixel of the window.
   task automatic push_txn(input int ch, input logic [7:0] x0, input logic [7:0] x1,
                           input logic [7:0] y0, input logic [7:0] y1, input logic [15:0] pbase);
      logic [7:0] b [11];
      word_t      w;
      int         n;
      b = '{8'h2A, 8'h00, x0, 8'h00, x1, 8'h2B, 8'h00, y0, 8'h00, y1, 8'h2C};
      for (int i = 0; i < 11; i++) begin
         w.data = {8'h00, b[i]};
         w.is16 = 1'b0;
         w.dc   = !(i == 0 || i == 5 || i == 10);
         w.cs_n = ~(4'b0001 << ch);
         exp_q.push_back(w);
      end
      if (x1 < x0 || y1 < y0) n = 0;
      else n = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
      for (int k = 0; k < n; k++) begin
         w.data = pbase + 16'(k);
         w.is16 = 1'b1;
         w.dc   = 1'b1;
         w.cs_n = ~(4'b0001 << ch);
         exp_q.push_back(w);
         src_q.push_back(pbase + 16'(k));
      end
      exp_gnt_q.push_back(ch);
   endtask

   task automatic set_win(input int ch, input logic [7:0] x0, input logic [7:0] x1,
                          input logic [7:0] y0, input logic [7:0] y1);
      win_x0[ch*8 +: 8] = x0;
      win_x1[ch*8 +: 8] = x1;
      win_y0[ch*8 +: 8] = y0;
      win_y1[ch*8 +: 8] = y1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk(gnt == 4'h0, {tag, "_gnt"}, gnt, 0);
      chk(done == 4'h0, {tag, "_done"}, done, 0);
      chk(pix_ready == 1'b0, {tag, "_pix_ready"}, pix_ready, 0);
      chk(d8_empty == 1'b1, {tag, "_d8_empty"}, d8_empty, 1);
      chk(d16_empty == 1'b1, {tag, "_d16_empty"}, d16_empty, 1);
      chk(d8_data == 8'h00, {tag, "_d8_data"}, d8_data, 0);
      chk(d16_data == 16'h0000, {tag, "_d16_data"}, d16_data, 0);
      chk(lcd_dc == 1'b0, {tag, "_lcd_dc"}, lcd_dc, 0);
      chk(lcd_cs_n == 4'hF, {tag, "_lcd_cs_n"}, lcd_cs_n, 4'hF);
   endtask

   task automatic wait_done(input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk); #3;
         n++;
      end
      chk(done_cnt >= target, "done_timeout", done_cnt, target);
   endtask

   // Serializer and pixel source, driven on the falling edge.
   initial begin
      d8_read = 1'b0; d16_read = 1'b0; lcd_busy = 1'b0;
      pix_valid = 1'b0; pix_data = '0;
      forever begin
         @(negedge clk);
         if (busy_cnt > 0) busy_cnt--;
         d8_read  = 1'b0;
         d16_read = 1'b0;
         if (busy_cnt == 0 && chk_on) begin
            if (d8_empty == 1'b0) begin
               d8_read = 1'b1;
               capture({8'h00, d8_data}, 1'b0);
               busy_cnt = wt;
            end else if (d16_empty == 1'b0) begin
               d16_read = 1'b1;
               capture(d16_data, 1'b1);
               busy_cnt = wt;
            end
         end
         lcd_busy  = (busy_cnt > 0);
         pix_valid = (src_q.size() != 0) && (!gate3 || (cyc % 3 == 0));
         pix_data  = pix_valid ? src_q[0] : 16'h0000;
         #1;
         if (pix_valid && pix_ready) void'(src_q.pop_front());
      end
   end

   // Per-cycle compare process.
   initial begin
      logic [3:0] prev_gnt, prev_done, prev_cs;
      logic       prev_dc, prev_busy, prev_e8, prev_e16;
      int         t_gnt, t_cs, t_done, e;
      bit         d8_wait, done_valid;
      wait (chk_on);
      @(negedge clk); #2;
      prev_gnt = gnt; prev_done = done; prev_cs = lcd_cs_n; prev_dc = lcd_dc;
      prev_busy = lcd_busy; prev_e8 = d8_empty; prev_e16 = d16_empty;
      t_gnt = 0; t_cs = 0; t_done = 0; d8_wait = 0; done_valid = 0;
      forever begin
         @(negedge clk); #2;
         cyc++;
         chk($countones(gnt) <= 1, "gnt_onehot", gnt, 0);
         chk(lcd_cs_n == 4'hF || lcd_cs_n == ~gnt, "cs_matches_gnt", lcd_cs_n, ~gnt);
         chk(d8_empty || d16_empty, "single_word_held", {d8_empty, d16_empty}, 3);
         if (pix_ready) chk(gnt != 4'h0, "ready_needs_gnt", gnt, 1);
         if (no_pix) chk(pix_ready == 1'b0, "no_pix_ready", pix_ready, 0);
         if (!rst && lcd_dc != prev_dc)
            chk(!prev_busy && prev_e8 && prev_e16, "dc_change_safe",
                {prev_busy, prev_e8, prev_e16}, 3'b011);
         if (gnt != 4'h0 && prev_gnt == 4'h0) begin
            chk(exp_gnt_q.size() != 0, "grant_expected", gnt, 0);
            if (exp_gnt_q.size() != 0) begin
               e = exp_gnt_q.pop_front();
               chk(gnt == (4'b0001 << e), "grant_owner", gnt, 4'b0001 << e);
            end
            for (int c = 0; c < 4; c++) if (gnt[c]) gnt_log.push_back(c);
            if (done_valid) chk(cyc - t_done >= CSH, "done_to_grant_gap", cyc - t_done, CSH);
            t_gnt = cyc;
         end
         if (lcd_cs_n != 4'hF && prev_cs == 4'hF) begin
            chk(cyc - t_gnt == 1, "grant_to_cs_low", cyc - t_gnt, 1);
            t_cs = cyc;
            d8_wait = 1;
         end
         if (d8_wait && !d8_empty) begin
            d8_wait = 0;
            chk(cyc - t_cs == CSS, "cs_low_to_first_byte", cyc - t_cs, CSS);
         end
         if (done != 4'h0) begin
            chk($onehot(done) && done == prev_gnt && prev_done == 4'h0 && gnt == 4'h0,
                "done_pulse", done, prev_gnt);
            done_cnt++;
            t_done = cyc;
            done_valid = 1;
         end
         if (rst) done_valid = 0;
         prev_gnt = gnt; prev_done = done; prev_cs = lcd_cs_n; prev_dc = lcd_dc;
         prev_busy = lcd_busy; prev_e8 = d8_empty; prev_e16 = d16_empty;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] lit_b [11];
      logic       lit_dc [11];
      int         lit_order [5];
      int         n, ok;
      lit_b  = '{8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0B, 8'h2B, 8'h00, 8'h14, 8'h00, 8'h14, 8'h2C};
      lit_dc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef LCD_SCHED_RR_EN
      lit_order = '{0, 1, 2, 3, 0};
`else
      lit_order = '{0, 0, 0, 0, 0};
`endif
      rst = 1'b1; req = '0;
      win_x0 = '0; win_x1 = '0; win_y0 = '0; win_y1 = '0;
      repeat (3) @(negedge clk);
      #3;
      check_reset_vals("reset");
      chk_on = 1;
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single request, ch2, window 10..11 x 20..20.
      wt = 3;
      set_win(2, 8'd10, 8'd11, 8'd20, 8'd20);
      push_txn(2, 8'd10, 8'd11, 8'd20, 8'd20, 16'h2000);
      log_q.delete();
      req = 4'b0100;
      wait_done(1, 2000);
      req = 4'b0000;
      repeat (5) @(negedge clk);
      chk(log_q.size() == 13, "t1_word_count", log_q.size(), 13);
      if (log_q.size() == 13) begin
         for (int i = 0; i < 11; i++) begin
            chk(log_q[i].data == {8'h00, lit_b[i]}, "t1_byte", log_q[i].data, lit_b[i]);
            chk(log_q[i].dc == lit_dc[i], "t1_byte_dc", log_q[i].dc, lit_dc[i]);
         end
         chk(log_q[0].cs_n == 4'b1011, "t1_cs_n", log_q[0].cs_n, 4'b1011);
         chk(log_q[11].is16 && log_q[12].is16 && log_q[11].dc && log_q[12].dc,
             "t1_pixels_dc1", {log_q[11].is16, log_q[12].dc}, 3);
      end
      chk(exp_q.size() == 0, "t1_stream_complete", exp_q.size(), 0);

      // 4x4 window on ch0, pixels offered 1 cycle in 3, slow serializer.
      wt = 17; gate3 = 1;
      set_win(0, 8'd0, 8'd3, 8'd0, 8'd3);
      push_txn(0, 8'd0, 8'd3, 8'd0, 8'd3, 16'h3000);
      log_q.delete();
      req = 4'b0001;
      wait_done(2, 6000);
      req = 4'b0000; gate3 = 0;
      repeat (5) @(negedge clk);
      chk(log_q.size() == 27, "t2_word_count", log_q.size(), 27);
      ok = 1;
      if (log_q.size() == 27)
         for (int k = 0; k < 16; k++) if (log_q[11+k].data != 16'h3000 + 16'(k)) ok = 0;
      chk(ok == 1 && log_q.size() == 27, "t2_pixel_order", ok, 1);
      chk(exp_q.size() == 0 && src_q.size() == 0, "t2_stream_complete", exp_q.size(), 0);

      // Swapped window on ch1: commands only, no pixels.
      wt = 3; no_pix = 1;
      set_win(1, 8'd5, 8'd4, 8'd0, 8'd0);
      push_txn(1, 8'd5, 8'd4, 8'd0, 8'd0, 16'h0000);
      log_q.delete();
      req = 4'b0010;
      wait_done(3, 2000);
      req = 4'b0000;
      repeat (5) @(negedge clk);
      no_pix = 0;
      chk(log_q.size() == 11, "t3_word_count", log_q.size(), 11);
      if (log_q.size() == 11) begin
         chk(log_q[2].data == 16'h0005, "t3_raw_x0", log_q[2].data, 5);
         chk(log_q[4].data == 16'h0004, "t3_raw_x1", log_q[4].data, 4);
      end

      // All four requests held: arbitration order.
      for (int c = 0; c < 4; c++) set_win(c, 8'(c), 8'(c), 8'd0, 8'd0);
      for (int k = 0; k < 5; k++)
         push_txn(lit_order[k], 8'(lit_order[k]), 8'(lit_order[k]), 8'd0, 8'd0, 16'h4000 + 16'(k * 16));
      gnt_log.delete();
      req = 4'b1111;
      wait_done(8, 5000);
      req = 4'b0000;
      repeat (10) @(negedge clk);
      chk(gnt == 4'h0, "t4_no_extra_grant", gnt, 0);
      chk(gnt_log.size() == 5, "t4_grant_count", gnt_log.size(), 5);
      if (gnt_log.size() == 5)
         for (int k = 0; k < 5; k++) chk(gnt_log[k] == lit_order[k], "t4_grant_order", gnt_log[k], lit_order[k]);
      chk(exp_q.size() == 0, "t4_stream_complete", exp_q.size(), 0);

      // Reset in the middle of the pixel phase.
      wt = 3;
      set_win(3, 8'd0, 8'd7, 8'd0, 8'd7);
      push_txn(3, 8'd0, 8'd7, 8'd0, 8'd7, 16'h5000);
      pix_seen = 0;
      req = 4'b1000;
      n = 0;
      while (pix_seen < 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(pix_seen >= 3, "t5_reach_pix", pix_seen, 3);
      @(negedge clk); #3;
      rst = 1'b1;
      @(negedge clk); #3;
      check_reset_vals("midpix");
      n = log_q.size();
      exp_q.delete(); src_q.delete(); exp_gnt_q.delete();
      req = 4'b0000;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk(log_q.size() == n, "t5_no_reads_after_reset", log_q.size(), n);
      chk(gnt == 4'h0 && lcd_cs_n == 4'hF, "t5_idle_after_reset", lcd_cs_n, 4'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
